// File: rtl/hilo_muldiv.sv
// HI/LO register pair with an iterative radix-2 multiplier and restoring divider.
// Optional macro HILO_FWD_EN forwards MTHI/MTLO data onto hi_o/lo_o in the write cycle.
module hilo_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] opa,
    input  logic [DATA_WIDTH-1:0] opb,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o,
    output logic                  busy,
    output logic                  done
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_MTHI  = 3'b001,
        OP_MTLO  = 3'b010,
        OP_MULT  = 3'b100,
        OP_MULTU = 3'b101,
        OP_DIV   = 3'b110,
        OP_DIVU  = 3'b111
    } op_t;

    state_t          state, state_nx;
    logic [W-1:0]    hi_q, lo_q;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  prod;     // {acc, multiplier} while multiplying, {rem, quotient} while dividing
    logic [W-1:0]    dvsr;     // multiplicand or divisor magnitude
    logic            is_mul, neg_p, neg_q, neg_r;

    logic            accept, is_md, is_divop, sgn, div_zero;
    logic [W-1:0]    abs_a, abs_b;
    logic [W:0]      mul_sum, div_shift, div_diff;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix, rem_fix;

    always_comb begin
        accept    = (state == IDLE) && start && !flush;
        is_md     = op[2];
        is_divop  = op[1];
        sgn       = ~op[0];
        div_zero  = (opb == '0);
        abs_a     = (sgn && opa[W-1]) ? -opa : opa;
        abs_b     = (sgn && opb[W-1]) ? -opb : opb;
        mul_sum   = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? dvsr : {W{1'b0}})};
        div_shift = prod[2*W-1:W-1];
        div_diff  = div_shift - {1'b0, dvsr};
        prod_fix  = neg_p ? -prod : prod;
        quo_fix   = neg_q ? -prod[W-1:0] : prod[W-1:0];
        rem_fix   = neg_r ? -prod[2*W-1:W] : prod[2*W-1:W];
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && is_md) begin
                    if (!is_divop)     state_nx = MUL;
                    else if (div_zero) state_nx = FIX;
                    else               state_nx = DIV;
                end
            end
            MUL, DIV: begin
                if (flush)              state_nx = IDLE;
                else if (cnt == LAST)   state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx != IDLE);
            done <= (state == FIX) && !flush;
            cnt  <= (state == MUL || state == DIV) ? cnt + 1'b1 : '0;
            if (accept && op == OP_MTHI) hi_q <= opa;
            if (accept && op == OP_MTLO) lo_q <= opa;
            if (state == FIX && !flush) begin
                if (is_mul) begin
                    {hi_q, lo_q} <= prod_fix;
                end else begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end
            end
        end
    end

    // NOTE: datapath registers are always loaded on accept before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept && is_md) begin
            is_mul <= !is_divop;
            if (!is_divop) begin
                dvsr  <= abs_a;
                prod  <= {{W{1'b0}}, abs_b};
                neg_p <= sgn & (opa[W-1] ^ opb[W-1]);
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else if (div_zero) begin
                prod  <= {opa, {W{1'b1}}};
                neg_p <= 1'b0;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else begin
                dvsr  <= abs_b;
                prod  <= {{W{1'b0}}, abs_a};
                neg_p <= 1'b0;
                neg_q <= sgn & (opa[W-1] ^ opb[W-1]);
                neg_r <= sgn & opa[W-1];
            end
        end else if (state == MUL) begin
            prod <= {mul_sum, prod[W-1:1]};
        end else if (state == DIV) begin
            prod <= div_diff[W] ? {div_shift[W-1:0], prod[W-2:0], 1'b0}
                                : {div_diff[W-1:0],  prod[W-2:0], 1'b1};
        end
    end

`ifdef HILO_FWD_EN
    assign hi_o = (start && !busy && op == OP_MTHI) ? opa : hi_q;
    assign lo_o = (start && !busy && op == OP_MTLO) ? opa : lo_q;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases plus random ops against an arithmetic model.
module tb_hilo_muldiv;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, flush;
    logic [2:0]   op;
    logic [W-1:0] opa, opb;
    logic [W-1:0] hi_o, lo_o;
    logic         busy, done;

    int           n_chk = 0;
    int           n_err = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    hilo_muldiv #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .flush(flush), .hi_o(hi_o), .lo_o(lo_o), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd1: m_hi = a;
            3'd2: m_lo = a;
            3'd4: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
            3'd5: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
            3'd6, 3'd7: begin
                if (b == 0) begin
                    m_hi = a;
                    m_lo = '1;
                end else if (o == 3'd6) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    q = 64'(sq);
                    r = 64'(sr);
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: ;
        endcase
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 100);
    endtask

    // Called at a negedge; returns at the negedge where the result is visible.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag);
        int lat;
        int exp_lat;
        op = o; opa = a; opb = b; start = 1'b1;
        model(o, a, b);
        @(negedge clk);
        start = 1'b0;
        if (o[2]) begin
            check({tag, " busy"}, busy, 1);
            exp_lat = (o[1] && b == 0) ? 1 : W + 1;
            wait_done(lat);
            check({tag, " latency"}, lat, exp_lat);
            check({tag, " busy_at_done"}, busy, 0);
        end else begin
            check({tag, " busy"}, busy, 0);
            check({tag, " done"}, done, 0);
        end
        check({tag, " hi"}, hi_o, m_hi);
        check({tag, " lo"}, lo_o, m_lo);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int            lat;
        int            n_done;
        logic [W-1:0]  a, b;
        logic [2:0]    o;
        logic [2:0]    ops [6] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};

        rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; opa = '0; opb = '0;
        repeat (2) @(negedge clk);
        check("reset hi", hi_o, 0);
        check("reset lo", lo_o, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst = 1'b1;

        do_op(3'd1, 32'h1234_5678, 32'h0, "mthi");
        do_op(3'd2, 32'h9ABC_DEF0, 32'h0, "mtlo");
        check("mthi const", hi_o, 32'h1234_5678);
        check("mtlo const", lo_o, 32'h9ABC_DEF0);

        do_op(3'd4, 32'hFFFF_FFFE, 32'd3, "mult");
        check("mult const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op(3'd5, 32'hFFFF_FFFE, 32'd3, "multu");
        check("multu const", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "div");
        check("div const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'd7, 32'd100, 32'd7, "divu");
        check("divu const", {hi_o, lo_o}, {32'd2, 32'd14});
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("div_ovf const", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
        do_op(3'd7, 32'd5, 32'd0, "divu0");
        check("divu0 const", {hi_o, lo_o}, 64'h0000_0005_FFFF_FFFF);
        do_op(3'd6, 32'hFFFF_FFF0, 32'd0, "div0");

        // Flush mid-MULT: no write, no done.
        op = 3'd4; opa = 32'h0000_1234; opb = 32'h0000_5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", busy, 0);
        check("flush done", done, 0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("flush no_done", n_done, 0);
        check("flush hi", hi_o, m_hi);
        check("flush lo", lo_o, m_lo);

        // Flush together with start in IDLE: start ignored.
        op = 3'd1; opa = 32'hAAAA_5555; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        op = 3'd4;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start hi", hi_o, m_hi);
        check("flush_start busy", busy, 0);

        // MTHI issued while busy is ignored.
        op = 3'd4; opa = 32'hFFFF_FF00; opb = 32'h0000_0101; start = 1'b1;
        model(3'd4, 32'hFFFF_FF00, 32'h0000_0101);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        op = 3'd1; opa = 32'hDEAD_BEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("mthi_busy latency", lat, W + 1 - 4);
        check("mthi_busy hi", hi_o, m_hi);
        check("mthi_busy lo", lo_o, m_lo);

        // Reset during DIV iteration 5.
        op = 3'd6; opa = 32'h1234_5678; opb = 32'h0000_0013; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_hi = '0;
        m_lo = '0;
        check("rst_mid hi", hi_o, 0);
        check("rst_mid lo", lo_o, 0);
        check("rst_mid busy", busy, 0);
        check("rst_mid done", done, 0);
        do_op(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_ff");
        check("multu_ff const", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);

        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 5)];
            a = rnd_val();
            b = ($urandom_range(0, 9) == 0) ? '0 : rnd_val();
            do_op(o, a, b, $sformatf("rand%0d op%0d", i, o));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
